// File: rtl/lc3_bus_arbiter.sv
`default_nettype none
// ============================================================================
// lc3_bus_arbiter : fixed-priority N-source bus with keeper and contention log
// Revision: 1.0
// ============================================================================
module lc3_bus_arbiter #(
    parameter int WIDTH = 16,
    parameter int N_SRC = 4,
    parameter int KEEP  = 1,
    parameter int CNT_W = 8
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [N_SRC-1:0]         gate,
    input  logic [N_SRC*WIDTH-1:0]   src_data,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         bus_out,
    output logic                     bus_valid,
    output logic                     contention,
    output logic [$clog2(N_SRC)-1:0] owner_idx,
    output logic                     err_sticky,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int IDX_W = $clog2(N_SRC);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [IDX_W-1:0] win_idx;
    logic [WIDTH-1:0] win_data;
    logic [WIDTH-1:0] idle_val;

    logic [IDX_W-1:0] owner_q, owner_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Descending scan so the lowest set index is the last, winning assignment.
    always_comb begin
        win_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (gate[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    assign win_data   = src_data[int'(win_idx)*WIDTH +: WIDTH];
    assign bus_valid  = |gate;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign contention = |(gate & (gate - N_SRC'(1)));
    assign bus_out    = bus_valid ? win_data : idle_val;

    generate
        if (KEEP != 0) begin : g_keep
            logic [WIDTH-1:0] keep_q, keep_d;

            always_comb begin
                keep_d = bus_valid ? win_data : keep_q;
            end

            always_ff @(posedge Clk) begin
                if (!Reset_n) begin
                    keep_q <= '0;
                end else begin
                    keep_q <= keep_d;
                end
            end

            assign idle_val = keep_q;
        end else begin : g_no_keep
            assign idle_val = '0;
        end
    endgenerate

    // A contention edge outranks err_clr: the new event is recorded as count 1.
    always_comb begin
        owner_d      = bus_valid ? win_idx : owner_q;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        if (contention) begin
            err_sticky_d = 1'b1;
            if (err_clr) begin
                err_cnt_d = CNT_W'(1);
            end else if (err_cnt_q != C_CNT_MAX) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            owner_q      <= '0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            owner_q      <= owner_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign owner_idx  = owner_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_lc3_bus_arbiter : scoreboard bench, KEEP=1 and KEEP=0 instances in parallel
// Revision: 1.0
// ============================================================================
module tb_lc3_bus_arbiter;

    localparam int WIDTH = 16;
    localparam int N_SRC = 4;
    localparam int CNT_W = 8;

    logic              Clk;
    logic              Reset_n;
    logic [N_SRC-1:0]  gate;
    logic [N_SRC*WIDTH-1:0] src_data;
    logic              err_clr;

    logic [WIDTH-1:0]  bus_out_k1, bus_out_k0;
    logic              bus_valid_k1, bus_valid_k0;
    logic              contention_k1, contention_k0;
    logic [1:0]        owner_k1, owner_k0;
    logic              sticky_k1, sticky_k0;
    logic [CNT_W-1:0]  cnt_k1, cnt_k0;

    lc3_bus_arbiter #(.WIDTH(WIDTH), .N_SRC(N_SRC), .KEEP(1), .CNT_W(CNT_W)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .gate(gate), .src_data(src_data),
        .err_clr(err_clr), .bus_out(bus_out_k1), .bus_valid(bus_valid_k1),
        .contention(contention_k1), .owner_idx(owner_k1),
        .err_sticky(sticky_k1), .err_cnt(cnt_k1)
    );

    lc3_bus_arbiter #(.WIDTH(WIDTH), .N_SRC(N_SRC), .KEEP(0), .CNT_W(CNT_W)) u_dut_nokeep (
        .Clk(Clk), .Reset_n(Reset_n), .gate(gate), .src_data(src_data),
        .err_clr(err_clr), .bus_out(bus_out_k0), .bus_valid(bus_valid_k0),
        .contention(contention_k0), .owner_idx(owner_k0),
        .err_sticky(sticky_k0), .err_cnt(cnt_k0)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic [15:0] bus1;
        logic [15:0] bus0;
        logic        valid;
        logic        cont;
        logic [1:0]  owner;
        logic        sticky;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] src[N_SRC];

    // Reference state: what the spec says the bus remembers between cycles.
    int m_keep, m_owner, m_sticky, m_cnt;

    function automatic int winner(input logic [3:0] g);
        for (int i = 0; i < N_SRC; i++) begin
            if (g[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle presents a full output set, compared mid-cycle.
    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("bus_out_keep",   int'(bus_out_k1),    int'(e.bus1));
            chk("bus_out_nokeep", int'(bus_out_k0),    int'(e.bus0));
            chk("bus_valid",      int'(bus_valid_k1),  int'(e.valid));
            chk("contention",     int'(contention_k1), int'(e.cont));
            chk("owner_idx",      int'(owner_k1),      int'(e.owner));
            chk("err_sticky",     int'(sticky_k1),     int'(e.sticky));
            chk("err_cnt",        int'(cnt_k1),        int'(e.cnt));
            chk("err_cnt_nokeep", int'(cnt_k0),        int'(e.cnt));
        end
    end

    task automatic cycle(input logic [3:0] g, input logic clr, input logic rn);
        exp_t e;
        int   w;
        int   ones;
        gate     = g;
        err_clr  = clr;
        Reset_n  = rn;
        src_data = {src[3], src[2], src[1], src[0]};
        w    = winner(g);
        ones = $countones(g);
        e.valid  = (w >= 0);
        e.cont   = (ones > 1);
        e.bus1   = (w >= 0) ? src[w] : 16'(m_keep);
        e.bus0   = (w >= 0) ? src[w] : 16'h0000;
        e.owner  = 2'(m_owner);
        e.sticky = 1'(m_sticky);
        e.cnt    = 8'(m_cnt);
        sb.push_back(e);
        @(posedge Clk);
        if (!rn) begin
            m_keep = 0; m_owner = 0; m_sticky = 0; m_cnt = 0;
        end else begin
            if (w >= 0) begin
                m_keep  = int'(src[w]);
                m_owner = w;
            end
            if (ones > 1) begin
                m_sticky = 1;
                m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            end else if (clr) begin
                m_sticky = 0;
                m_cnt    = 0;
            end
        end
        #1;
    endtask

    task automatic rand_src();
        for (int i = 0; i < N_SRC; i++) src[i] = 16'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        gate = '0; err_clr = 1'b0; Reset_n = 1'b0;
        for (int i = 0; i < N_SRC; i++) src[i] = 16'h0000;
        src_data = '0;
        m_keep = 0; m_owner = 0; m_sticky = 0; m_cnt = 0;
        @(posedge Clk);
        #1;

        // Post-reset idle
        cycle(4'b0000, 1'b0, 1'b1);

        // Single source, then idle keeper vs zero
        src[1] = 16'h3000;
        cycle(4'b0010, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);

        // Two gates: lower index wins, contention logged
        src[1] = 16'h1111; src[2] = 16'h2222;
        cycle(4'b0110, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);

        // Saturation of the counter
        src[0] = 16'hA5A5; src[3] = 16'h5A5A;
        repeat (300) cycle(4'b1001, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);

        // Set beats clear, then plain clear
        cycle(4'b0000, 1'b1, 1'b1);
        repeat (5) begin
            rand_src();
            cycle(4'b0011, 1'b0, 1'b1);
        end
        cycle(4'b0011, 1'b1, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);

        // Reset drops the held value
        src[0] = 16'hBEEF;
        cycle(4'b0001, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1);

        repeat (2000) begin
            logic [3:0] g;
            rand_src();
            case ($urandom_range(0, 3))
                0:       g = 4'b0000;
                1:       g = 4'(1 << $urandom_range(0, 3));
                default: g = 4'($urandom_range(0, 15));
            endcase
            cycle(g, ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) != 0));
        end

        gate = '0; err_clr = 1'b0; Reset_n = 1'b1;
        repeat (4) @(posedge Clk);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
